// File: rtl/tt_proj_sel_ctrl.sv
// ============================================================================
// Module  : tt_proj_sel_ctrl
// Brief   : Project-slot select controller: guard gap, timed project reset, run.
//           Optional select counter output enabled by TT_PROJ_SEL_CTRL_SWCOUNT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_proj_sel_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int GUARD_CYC = 2,
  parameter int RST_CYC   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_off,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic                   ext_rst_n,
  output logic [2**ADDR_W-1:0]   proj_ena,
  output logic                   proj_rst_n,
  output logic [ADDR_W-1:0]      cur_addr,
`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
  output logic                   cur_valid,
  output logic [7:0]             sw_count
`else
  output logic                   cur_valid
`endif
);

  localparam int         NPROJ        = 2**ADDR_W;
  localparam logic [7:0] c_GUARD_LAST = 8'(GUARD_CYC - 1);
  localparam logic [7:0] c_RST_LAST   = 8'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_RESET = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   w_target_nxt;
  logic                r_off;
  logic                w_off_nxt;
  logic                w_accept;

  logic                r_cmd_ready;
  logic [NPROJ-1:0]    r_proj_ena;
  logic                r_proj_rst_n;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic                r_cur_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_off_nxt    = r_off;
    w_accept     = cmd_valid & r_cmd_ready;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept) begin
          w_state_nxt  = S_GUARD;
          w_cnt_nxt    = 8'd0;
          w_target_nxt = cmd_addr;
          w_off_nxt    = cmd_off;
        end
      end
      S_GUARD: begin
        if (r_cnt == c_GUARD_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = r_off ? S_IDLE : S_RESET;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_RESET: begin
        if (r_cnt == c_RST_LAST) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_target     <= '0;
      r_off        <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_proj_ena   <= '0;
      r_proj_rst_n <= 1'b0;
      r_cur_addr   <= '0;
      r_cur_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_off        <= w_off_nxt;
      r_cmd_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN);
      r_proj_ena   <= ((w_state_nxt == S_RESET) || (w_state_nxt == S_RUN))
                      ? (NPROJ'(1) << w_target_nxt) : '0;
      r_proj_rst_n <= (w_state_nxt == S_RUN) ? ext_rst_n : 1'b0;
      r_cur_valid  <= (w_state_nxt == S_RUN);
      if (w_state_nxt == S_RESET) begin
        r_cur_addr <= w_target_nxt;
      end
    end
  end

`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
  logic [7:0] r_sw_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_count <= 8'd0;
    end else if ((r_state == S_RESET) && (w_state_nxt == S_RUN) && (r_sw_count != 8'hFF)) begin
      r_sw_count <= r_sw_count + 8'd1;
    end
  end

  assign sw_count = r_sw_count;
`endif

  assign cmd_ready  = r_cmd_ready;
  assign proj_ena   = r_proj_ena;
  assign proj_rst_n = r_proj_rst_n;
  assign cur_addr   = r_cur_addr;
  assign cur_valid  = r_cur_valid;

endmodule

`default_nettype wire

// File: tb/tb_tt_proj_sel_ctrl.sv
// ============================================================================
// Module  : tb_tt_proj_sel_ctrl
// Brief   : Self-checking bench for tt_proj_sel_ctrl (timeline model + literals).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_proj_sel_ctrl;

  localparam int ADDR_W = 4;
  localparam int NPROJ  = 16;
  localparam int G      = 2;
  localparam int R      = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_off;
  logic [ADDR_W-1:0] cmd_addr;
  logic              ext_rst_n;
  logic [NPROJ-1:0]  proj_ena;
  logic              proj_rst_n;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_valid;
`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
  logic [7:0]        sw_count;
`endif

  int checks = 0;
  int errors = 0;

  tt_proj_sel_ctrl #(.ADDR_W(ADDR_W), .GUARD_CYC(G), .RST_CYC(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_off    (cmd_off),
    .cmd_addr   (cmd_addr),
    .ext_rst_n  (ext_rst_n),
    .proj_ena   (proj_ena),
    .proj_rst_n (proj_rst_n),
    .cur_addr   (cur_addr),
`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
    .cur_valid  (cur_valid),
    .sw_count   (sw_count)
`else
    .cur_valid  (cur_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: outputs follow from the edge count elapsed since the last accept.
  int                n = 0;
  int                m_tacc;
  int                d;
  logic              m_cmd;
  logic              m_off;
  logic [ADDR_W-1:0] m_tgt;
  logic [ADDR_W-1:0] m_prev;
  logic              acc;
  logic              e_ready;
  logic [NPROJ-1:0]  e_ena;
  logic              e_rstn;
  logic [ADDR_W-1:0] e_addr;
  logic              e_valid;
  int                e_sw;

  always @(posedge clk) begin
    if (rst) begin
      m_cmd = 1'b0; e_ready = 1'b0; e_ena = '0; e_rstn = 1'b0;
      e_addr = '0; e_valid = 1'b0; e_sw = 0;
    end else begin
      acc = cmd_valid && e_ready;
      if (acc) begin
        m_cmd = 1'b1; m_tacc = n; m_off = cmd_off; m_tgt = cmd_addr; m_prev = e_addr;
      end
      if (!m_cmd) begin
        e_ready = 1'b1; e_ena = '0; e_rstn = 1'b0; e_valid = 1'b0;
      end else begin
        d = n - m_tacc + 1;
        if (d <= G) begin
          e_ready = 1'b0; e_ena = '0; e_rstn = 1'b0; e_valid = 1'b0; e_addr = m_prev;
        end else if (m_off) begin
          e_ready = 1'b1; e_ena = '0; e_rstn = 1'b0; e_valid = 1'b0; e_addr = m_prev;
        end else if (d <= G + R) begin
          e_ready = 1'b0; e_ena = '0; e_ena[m_tgt] = 1'b1; e_rstn = 1'b0;
          e_valid = 1'b0; e_addr = m_tgt;
        end else begin
          e_ready = 1'b1; e_ena = '0; e_ena[m_tgt] = 1'b1; e_rstn = ext_rst_n;
          e_valid = 1'b1; e_addr = m_tgt;
          if (d == G + R + 1 && e_sw < 255) e_sw = e_sw + 1;
        end
      end
    end
    n++;
  end

  always @(posedge clk) begin
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    chk("proj_ena", 32'(proj_ena), 32'(e_ena));
    chk("proj_rst_n", 32'(proj_rst_n), 32'(e_rstn));
    chk("cur_addr", 32'(cur_addr), 32'(e_addr));
    chk("cur_valid", 32'(cur_valid), 32'(e_valid));
    chk("ena_onehot", 32'($countones(proj_ena) <= 1), 32'd1);
`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
    chk("sw_count", 32'(sw_count), 32'(e_sw));
`endif
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_off = 1'b0; cmd_addr = '0; ext_rst_n = 1'b1;
    tick(3);
    chk("lit_rst_ready", 32'(cmd_ready), 32'd0);
    chk("lit_rst_ena", 32'(proj_ena), 32'd0);
    chk("lit_rst_addr", 32'(cur_addr), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("lit_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Select slot 5 from idle
    cmd_valid = 1'b1; cmd_addr = 4'd5; tick(1); cmd_valid = 1'b0;
    chk("lit_sel5_t1_ena", 32'(proj_ena), 32'd0);
    tick(1);
    chk("lit_sel5_t2_ena", 32'(proj_ena), 32'd0);
    tick(1);
    chk("lit_sel5_t3_ena", 32'(proj_ena), 32'h0020);
    chk("lit_sel5_t3_rstn", 32'(proj_rst_n), 32'd0);
    tick(9);
    chk("lit_sel5_t12_rstn", 32'(proj_rst_n), 32'd0);
    tick(1);
    chk("lit_sel5_t13_rstn", 32'(proj_rst_n), 32'd1);
    chk("lit_sel5_t13_valid", 32'(cur_valid), 32'd1);

    // Switch slot 5 -> 9
    cmd_valid = 1'b1; cmd_addr = 4'd9; tick(1); cmd_valid = 1'b0;
    chk("lit_sel9_t1_ena", 32'(proj_ena), 32'd0);
    tick(2);
    chk("lit_sel9_t3_ena", 32'(proj_ena), 32'h0200);
    tick(10);
    chk("lit_sel9_run", 32'(cur_valid), 32'd1);

    // User reset pulse, 3 cycles low
    ext_rst_n = 1'b0;
    tick(1); chk("lit_ext_p1", 32'(proj_rst_n), 32'd0);
    tick(1); tick(1); ext_rst_n = 1'b1;
    chk("lit_ext_p3", 32'(proj_rst_n), 32'd0);
    tick(1); chk("lit_ext_rel", 32'(proj_rst_n), 32'd1);

    // Re-select the running slot
    cmd_valid = 1'b1; cmd_addr = 4'd9; tick(1); cmd_valid = 1'b0;
    chk("lit_resel_ena", 32'(proj_ena), 32'd0);
    tick(12);
    chk("lit_resel_run", 32'(proj_ena), 32'h0200);

    // Deselect from run
    cmd_valid = 1'b1; cmd_off = 1'b1; tick(1); cmd_valid = 1'b0; cmd_off = 1'b0;
    chk("lit_off_ena", 32'(proj_ena), 32'd0);
    tick(2);
    chk("lit_off_ready", 32'(cmd_ready), 32'd1);
    chk("lit_off_valid", 32'(cur_valid), 32'd0);
    chk("lit_off_addr", 32'(cur_addr), 32'd9);

    // Deselect while idle
    cmd_valid = 1'b1; cmd_off = 1'b1; tick(1); cmd_valid = 1'b0; cmd_off = 1'b0;
    chk("lit_idle_off_ready", 32'(cmd_ready), 32'd0);
    tick(2);
    chk("lit_idle_off_back", 32'(cmd_ready), 32'd1);

    // Reset mid-RESET of slot 3, stray command ignored
    cmd_valid = 1'b1; cmd_addr = 4'd3; tick(1); cmd_valid = 1'b0;
    tick(2);
    chk("lit_sel3_ena", 32'(proj_ena), 32'h0008);
    cmd_valid = 1'b1; cmd_addr = 4'd7;
    tick(3);
    chk("lit_sel3_ignored", 32'(cur_addr), 32'd3);
    rst = 1'b1; cmd_valid = 1'b0;
    tick(1);
    chk("lit_midrst_ena", 32'(proj_ena), 32'd0);
    chk("lit_midrst_addr", 32'(cur_addr), 32'd0);
    chk("lit_midrst_rstn", 32'(proj_rst_n), 32'd0);
    rst = 1'b0;
    tick(1);

`ifdef TT_PROJ_SEL_CTRL_SWCOUNT_EN
    chk("lit_sw_zero", 32'(sw_count), 32'd0);
    for (int i = 0; i < 256; i++) begin
      cmd_valid = 1'b1; cmd_addr = 4'(i); tick(1); cmd_valid = 1'b0;
      tick(12);
    end
    chk("lit_sw_sat", 32'(sw_count), 32'd255);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/tt_proj_sel_ctrl.md
TT_PROJ_SEL_CTRL -- requirements
Module: tt_proj_sel_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: project address width; NPROJ = 2**ADDR_W project slots.
REQ-002 Parameter GUARD_CYC, default 2: idle cycles with all ena low between deselect and select (range 1..15).
REQ-003 Parameter RST_CYC, default 10: cycles proj_rst_n is held low after ena rises (range 1..255).
REQ-004 clk  input  1  single clock for all state; no other clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted on the cycle cmd_valid & cmd_ready are both high.
REQ-008 cmd_off  input  1  1 = deselect all projects; 0 = select cmd_addr.
REQ-009 cmd_addr  input  ADDR_W  target project slot.
REQ-010 ext_rst_n  input  1  user reset request, active-low, forwarded in RUN.
REQ-011 proj_ena  output  NPROJ  one-hot or zero enable per project slot.
REQ-012 proj_rst_n  output  1  reset to the selected project, active-low.
REQ-013 cur_addr  output  ADDR_W  address of the selected/being-selected slot.
REQ-014 cur_valid  output  1  high only in RUN.

Function
REQ-015 FSM states: IDLE, GUARD, RESET, RUN.
REQ-016 cmd_ready SHALL be high in IDLE and RUN, low in GUARD and RESET.
REQ-017 Command accept latches cmd_addr into a target register and cmd_off into a pending-off flag; state moves to GUARD next cycle.
REQ-018 GUARD: proj_ena all zero, proj_rst_n low, counter runs GUARD_CYC cycles; then RESET if pending-off is 0, else IDLE.
REQ-019 RESET: proj_ena[target]=1, proj_rst_n=0, cur_addr=target, for exactly RST_CYC cycles; then RUN.
REQ-020 RUN: proj_ena[target]=1, proj_rst_n = ext_rst_n (registered, 1-cycle latency), cur_valid=1.
REQ-021 IDLE: proj_ena=0, proj_rst_n=0, cur_valid=0; cur_addr holds its last value.
REQ-022 All outputs SHALL be registered; proj_ena SHALL never have more than one bit set in any cycle.
REQ-023 Command to the current address in RUN SHALL run the full GUARD+RESET sequence (re-select = project reset).
REQ-024 cmd_off in IDLE SHALL pass through GUARD and return to IDLE (no ena pulse).
REQ-025 cmd_valid while cmd_ready low SHALL be ignored, not queued; cmd_valid must be held by the requester.
REQ-026 Accept-to-ena latency: accept cycle T, proj_ena rises at T+1+GUARD_CYC; proj_rst_n rises at T+1+GUARD_CYC+RST_CYC.

Reset
REQ-027 rst high at any clock edge, including mid-GUARD or mid-RESET, SHALL force IDLE: proj_ena=0, proj_rst_n=0, cur_addr=0, cur_valid=0, counters=0, pending-off=0, cmd_ready=0 during rst, 1 the cycle after rst falls.

Configuration
REQ-028 Macro TT_PROJ_SEL_CTRL_SWCOUNT_EN defined: adds output sw_count[7:0], reset 0, +1 on each RESET->RUN transition, saturating at 255.
REQ-029 Macro undefined: port sw_count absent; all other behaviour identical.

Verification
REQ-030 Reset release, cmd_addr=5 accepted at T -> proj_ena=0 through T+2, proj_ena=0x0020 at T+3, proj_rst_n low until T+12, high at T+13, cur_valid high at T+13.
REQ-031 In RUN on slot 5, select slot 9 -> proj_ena 0x0020 -> 0x0000 for 2 cycles -> 0x0200; no cycle with two bits set.
REQ-032 In RUN, cmd_off=1 -> proj_ena=0 next cycle, IDLE after 2 guard cycles, cur_valid=0, cmd_ready=1.
REQ-033 rst asserted on 4th RESET cycle of slot 3 -> next cycle proj_ena=0, proj_rst_n=0, cur_addr=0; cmd_valid during RESET ignored.
REQ-034 In RUN, ext_rst_n pulsed low 3 cycles -> proj_rst_n low 3 cycles delayed by 1; with SWCOUNT_EN, 256 selects -> sw_count=255.
